// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake bundle for the bit-serial subtractor: operation request
// (start_*) and result return (result_*), each with valid/ready flow control.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    // Valid/ready rule for both channels: a transfer happens on a rising
    // clk edge where valid and ready are both 1. The producer holds its
    // payload stable while valid is high and ready is low. The consumer's
    // ready never depends combinationally on valid.
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             borrow_in;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    // Requester / result consumer side
    modport master (
        output start_valid, minuend, subtrahend, borrow_in, result_ready,
        input  start_ready, result_valid, diff, borrow_out, zero
    );

    // Subtraction controller side
    modport slave (
        input  start_valid, minuend, subtrahend, borrow_in, result_ready,
        output start_ready, result_valid, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell is stepped
// LSB-first over the operands, one bit per clock, with a registered borrow.

// Single-bit subtract cell: d = a - b - bin, bout = borrow to the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_ctrl_if.slave  bus,
    output logic [1:0]               dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only the upper WIDTH-1 result bits need storage: the final bit is
    // produced on the completion edge and goes straight into diff.
    logic [WIDTH-1:1] r_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             start_ready_q;
    logic             result_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             zero_q;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] r_next;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Result word as it stands after the current bit is shifted in at the MSB
    assign r_next = {fs_d, r_sr};

    // Control FSM plus datapath registers; all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            a_sr           <= '0;
            b_sr           <= '0;
            r_sr           <= '0;
            borrow         <= 1'b0;
            cnt            <= '0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            diff_q         <= '0;
            borrow_out_q   <= 1'b0;
            zero_q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        a_sr          <= bus.minuend;
                        b_sr          <= bus.subtrahend;
                        borrow        <= bus.borrow_in;
                        cnt           <= '0;
                        start_ready_q <= 1'b0;
                        state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sr   <= r_next[WIDTH-1:1];
                    borrow <= fs_bout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        diff_q         <= r_next;
                        borrow_out_q   <= fs_bout;
                        zero_q         <= (r_next == '0);
                        result_valid_q <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    result_valid_q <= 1'b0;
                    start_ready_q  <= 1'b1;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.diff         = diff_q;
    assign bus.borrow_out   = borrow_out_q;
    assign bus.zero         = zero_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl (WIDTH=8): directed cases, backpressure,
// asynchronous reset mid-operation and a random back-to-back stream,
// checked against an arithmetic reference model.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int tests_run;
    int tests_failed;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock: 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected results queued as {borrow, zero, diff}
    logic [W+1:0] exp_q[$];

    // Reference: plain unsigned arithmetic on the operands
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic bin);
        int          ia;
        int          ib;
        int          r;
        logic [W-1:0] d;
        logic         bo;
        ia = int'(a);
        ib = int'(b) + int'(bin);
        bo = (ia < ib);
        r  = ia - ib + (1 << W);
        d  = W'(r % (1 << W));
        return {bo, (d == '0), d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_operands();
        bus.minuend    = W'($urandom_range(0, (1 << W) - 1));
        bus.subtrahend = W'($urandom_range(0, (1 << W) - 1));
        bus.borrow_in  = 1'($urandom_range(0, 1));
    endtask

    // Issue one operation, measure latency, check the result, optionally ack
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input bit ack);
        int           n;
        logic [W+1:0] exp;
        exp = model(a, b, bin);
        n = 0;
        while (!bus.start_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_start_ready"}, 64'(bus.start_ready), 64'(1));
        bus.minuend     = a;
        bus.subtrahend  = b;
        bus.borrow_in   = bin;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        scramble_operands();
        n = 0;
        while (!bus.result_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
        check({tag, "_diff"}, 64'(bus.diff), 64'(exp[W-1:0]));
        check({tag, "_borrow"}, 64'(bus.borrow_out), 64'(exp[W+1]));
        check({tag, "_zero"}, 64'(bus.zero), 64'(exp[W]));
        if (ack) begin
            bus.result_ready = 1'b1;
            tick();
            bus.result_ready = 1'b0;
        end
    endtask

    // Directed sequence followed by random back-to-back traffic
    initial begin
        logic [W+1:0] held;
        logic [W+1:0] exp;
        int           cyc;
        int           accepts;
        int           got;
        int           last_acc;
        bit           offered;

        tests_run        = 0;
        tests_failed     = 0;
        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.minuend      = '0;
        bus.subtrahend   = '0;
        bus.borrow_in    = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_start_ready", 64'(bus.start_ready), 64'(1));
        check("rst_result_valid", 64'(bus.result_valid), 64'(0));
        check("rst_diff", 64'(bus.diff), 64'(0));
        check("rst_borrow", 64'(bus.borrow_out), 64'(0));
        check("rst_zero", 64'(bus.zero), 64'(0));
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases
        do_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b1);
        do_op("under", 8'h3C, 8'h5A, 1'b0, 1'b1);
        do_op("zero_minus_bin", 8'h00, 8'h00, 1'b1, 1'b1);
        do_op("bin_to_zero", 8'h80, 8'h7F, 1'b1, 1'b1);
        do_op("max_minus_max", 8'hFF, 8'hFF, 1'b0, 1'b1);

        // Backpressure: result held, new start pulse ignored
        do_op("bp", 8'h33, 8'h11, 1'b0, 1'b0);
        held = model(8'h33, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = (i == 2);
            bus.minuend     = 8'hC3;
            bus.subtrahend  = 8'h01;
            tick();
            check("bp_valid_hold", 64'(bus.result_valid), 64'(1));
            check("bp_start_ready", 64'(bus.start_ready), 64'(0));
            check("bp_diff_hold", 64'(bus.diff), 64'(held[W-1:0]));
            check("bp_flags_hold", 64'({bus.borrow_out, bus.zero}), 64'(held[W+1:W]));
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("bp_idle_ready", 64'(bus.start_ready), 64'(1));
        check("bp_idle_valid", 64'(bus.result_valid), 64'(0));
        check("bp_idle_diff", 64'(bus.diff), 64'(held[W-1:0]));
        tick();
        check("bp_no_extra_accept", 64'(bus.start_ready), 64'(1));

        // Asynchronous reset after bit 3 of FF - 01
        bus.minuend     = 8'hFF;
        bus.subtrahend  = 8'h01;
        bus.borrow_in   = 1'b0;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_start_ready", 64'(bus.start_ready), 64'(1));
        check("arst_valid", 64'(bus.result_valid), 64'(0));
        check("arst_diff", 64'(bus.diff), 64'(0));
        check("arst_flags", 64'({bus.borrow_out, bus.zero}), 64'(0));
        tick();
        rst_n = 1'b1;
        offered = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.result_valid) offered = 1'b1;
        end
        check("arst_no_valid", 64'(offered), 64'(0));
        do_op("post_rst", 8'h10, 8'h01, 1'b0, 1'b1);

        // Back-to-back: start_valid and result_ready held high
        cyc      = 0;
        accepts  = 0;
        got      = 0;
        last_acc = -1;
        bus.result_ready = 1'b1;
        while (got < 20 && cyc < 600) begin
            offered = 1'b0;
            if (bus.start_ready && accepts < 20) begin
                scramble_operands();
                exp_q.push_back(model(bus.minuend, bus.subtrahend, bus.borrow_in));
                offered = 1'b1;
            end else begin
                scramble_operands();
            end
            bus.start_valid = (accepts < 20);
            if (bus.result_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected", 64'(1), 64'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check("b2b_diff", 64'(bus.diff), 64'(exp[W-1:0]));
                    check("b2b_borrow", 64'(bus.borrow_out), 64'(exp[W+1]));
                    check("b2b_zero", 64'(bus.zero), 64'(exp[W]));
                end
                got++;
            end
            tick();
            cyc++;
            if (offered) begin
                if (last_acc >= 0) check("b2b_interval", 64'(cyc - last_acc), 64'(W + 2));
                last_acc = cyc;
                accepts++;
            end
        end
        check("b2b_results", 64'(got), 64'(20));
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
